// File: rtl/seq_fsm.sv
// Run/wait sequencer: timed RUN passes, optional auto-repeat, abort on stop, registered status pulses.
// Optional WAIT timeout counter is compiled in when SEQ_FSM_TIMEOUT_EN is defined.
module seq_fsm #(
   parameter int CNT_W = 8,
   parameter int REP_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [CNT_W-1:0] run_len,
   input  logic [REP_W-1:0] rep_cnt,
   input  logic [CNT_W-1:0] wait_tmo,
   output logic [1:0]       state,
   output logic             busy,
   output logic [REP_W-1:0] pass_idx,
   output logic             done,
   output logic             abort,
   output logic             tmo
);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t           st_q, st_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             mode_q, mode_d;
   logic [REP_W-1:0] rem_q, rem_d;
   logic [REP_W-1:0] pidx_q, pidx_d;
   logic             busy_q;
   logic             done_q, done_d;
   logic             abort_q, abort_d;
   logic             tmo_q, tmo_d;
   logic             tmo_hit;
   logic [CNT_W-1:0] len_eff;

   // A zero run length still occupies one RUN cycle.
   assign len_eff = (run_len == '0) ? CNT_W'(1) : run_len;

`ifdef SEQ_FSM_TIMEOUT_EN
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // Counter value 0 means the timeout is disabled for this WAIT visit.
   assign tmo_hit = (tmo_cnt_q == CNT_W'(1));
`else
   logic unused_wait_tmo;

   assign unused_wait_tmo = ^wait_tmo;
   assign tmo_hit         = 1'b0;
`endif

   always_comb begin
      st_d      = st_q;
      run_cnt_d = run_cnt_q;
      len_d     = len_q;
      mode_d    = mode_q;
      rem_d     = rem_q;
      pidx_d    = pidx_q;
      done_d    = 1'b0;
      abort_d   = 1'b0;
      tmo_d     = 1'b0;
`ifdef SEQ_FSM_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
`endif
      case (st_q)
         S_INIT: begin
            if (start) begin
               st_d      = S_RUN;
               len_d     = len_eff;
               run_cnt_d = len_eff;
               mode_d    = mode;
               rem_d     = rep_cnt;
               pidx_d    = '0;
            end
         end
         S_RUN: begin
            if (stop) begin
               st_d    = S_INIT;
               abort_d = 1'b1;
            end else if (run_cnt_q <= CNT_W'(1)) begin
               if (mode_q && (rem_q != '0)) begin
                  rem_d     = rem_q - REP_W'(1);
                  pidx_d    = pidx_q + REP_W'(1);
                  run_cnt_d = len_q;
               end else begin
                  st_d = S_WAIT;
`ifdef SEQ_FSM_TIMEOUT_EN
                  tmo_cnt_d = wait_tmo;
`endif
               end
            end else begin
               run_cnt_d = run_cnt_q - CNT_W'(1);
            end
         end
         S_WAIT: begin
            // stop wins over a coincident timeout
            if (stop) begin
               st_d   = S_INIT;
               done_d = 1'b1;
            end else if (tmo_hit) begin
               st_d  = S_INIT;
               tmo_d = 1'b1;
            end
`ifdef SEQ_FSM_TIMEOUT_EN
            if (tmo_cnt_q != '0) tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
`endif
         end
         default: begin
            st_d = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= S_INIT;
         run_cnt_q <= '0;
         len_q     <= '0;
         mode_q    <= 1'b0;
         rem_q     <= '0;
         pidx_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         st_q      <= st_d;
         run_cnt_q <= run_cnt_d;
         len_q     <= len_d;
         mode_q    <= mode_d;
         rem_q     <= rem_d;
         pidx_q    <= pidx_d;
         busy_q    <= (st_d == S_RUN);
         done_q    <= done_d;
         abort_q   <= abort_d;
         tmo_q     <= tmo_d;
      end
   end

`ifdef SEQ_FSM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_cnt_q <= '0;
      else        tmo_cnt_q <= tmo_cnt_d;
   end
`endif

   assign state    = st_q;
   assign busy     = busy_q;
   assign pass_idx = pidx_q;
   assign done     = done_q;
   assign abort    = abort_q;
   assign tmo      = tmo_q;

endmodule

// File: tb/tb_seq_fsm.sv
// Directed bench for seq_fsm: reset, one-shot, repeat, abort, timeout/hold and edge-input cases.
`timescale 1ns/1ps
module tb_seq_fsm;

   localparam int CNT_W = 8;
   localparam int REP_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, stop, mode;
   logic [CNT_W-1:0] run_len, wait_tmo;
   logic [REP_W-1:0] rep_cnt;
   logic [1:0]       state;
   logic             busy, done, abort, tmo;
   logic [REP_W-1:0] pass_idx;

   int checks   = 0;
   int failures = 0;
   int n;

   seq_fsm #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
      .run_len(run_len), .rep_cnt(rep_cnt), .wait_tmo(wait_tmo),
      .state(state), .busy(busy), .pass_idx(pass_idx),
      .done(done), .abort(abort), .tmo(tmo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Count consecutive cycles with busy high, bounded so a stuck DUT still ends.
   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy && cnt < 50) begin
         cnt++;
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 0; stop = 0; mode = 0;
      run_len = 8'd0; rep_cnt = 4'd0; wait_tmo = 8'd0;
      #3;
      chk("rst_state", 32'(state), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pidx", 32'(pass_idx), 0);
      chk("rst_pulses", 32'({done, abort, tmo}), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Reset mid-RUN acts without a clock edge
      run_len = 8'd10; start = 1;
      tick();
      start = 0;
      chk("mr_state_run", 32'(state), 1);
      tick(); tick(); tick();
      chk("mr_still_run", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_async_state", 32'(state), 0);
      chk("mr_async_busy", 32'(busy), 0);
      chk("mr_async_pidx", 32'(pass_idx), 0);
      #1 rst_n = 1'b1;
      tick();
      chk("mr_stay_init", 32'(state), 0);

      // One-shot, run_len 3
      mode = 0; run_len = 8'd3; start = 1;
      tick();
      start = 0;
      chk("os_state_run", 32'(state), 1);
      count_busy(n);
      chk("os_busy_cycles", 32'(n), 3);
      chk("os_state_wait", 32'(state), 2);
      stop = 1;
      tick();
      stop = 0;
      chk("os_state_init", 32'(state), 0);
      chk("os_done", 32'(done), 1);
      tick();
      chk("os_done_drop", 32'(done), 0);

      // Repeat: rep_cnt 2, run_len 2 -> pass_idx 0,0,1,1,2,2
      mode = 1; rep_cnt = 4'd2; run_len = 8'd2; start = 1;
      tick();
      start = 0; mode = 0; rep_cnt = 4'd9; run_len = 8'd7;
      for (int i = 0; i < 6; i++) begin
         chk("rp_state", 32'(state), 1);
         chk("rp_pidx", 32'(pass_idx), 32'(i / 2));
         tick();
      end
      chk("rp_wait", 32'(state), 2);
      chk("rp_pidx_final", 32'(pass_idx), 2);
      stop = 1;
      tick();
      stop = 0;
      chk("rp_done", 32'(done), 1);
      chk("rp_pidx_hold", 32'(pass_idx), 2);
      tick();

      // Abort on 2nd RUN cycle
      mode = 0; run_len = 8'd5; start = 1;
      tick();
      start = 0;
      tick();
      chk("ab_run2", 32'(state), 1);
      stop = 1;
      tick();
      stop = 0;
      chk("ab_state", 32'(state), 0);
      chk("ab_abort", 32'(abort), 1);
      chk("ab_done", 32'(done), 0);
      tick();
      chk("ab_abort_drop", 32'(abort), 0);

      // Abort on final cycle of the last pass
      mode = 1; rep_cnt = 4'd1; run_len = 8'd2; start = 1;
      tick();
      start = 0;
      tick(); tick(); tick();
      chk("abf_pidx", 32'(pass_idx), 1);
      stop = 1;
      tick();
      stop = 0;
      chk("abf_state", 32'(state), 0);
      chk("abf_abort", 32'(abort), 1);
      tick();

`ifdef SEQ_FSM_TIMEOUT_EN
      // Timeout after exactly 4 WAIT cycles
      mode = 0; run_len = 8'd1; wait_tmo = 8'd4; start = 1;
      tick();
      start = 0;
      tick();
      wait_tmo = 8'd0;
      n = 0;
      while (state == 2'd2 && n < 50) begin
         n++;
         tick();
      end
      chk("to_wait_cycles", 32'(n), 4);
      chk("to_state", 32'(state), 0);
      chk("to_tmo", 32'(tmo), 1);
      chk("to_done", 32'(done), 0);
      tick();
      chk("to_tmo_drop", 32'(tmo), 0);

      // stop coincident with expiry
      wait_tmo = 8'd4; start = 1;
      tick();
      start = 0;
      tick();
      wait_tmo = 8'd0;
      tick(); tick(); tick();
      chk("toc_wait4", 32'(state), 2);
      stop = 1;
      tick();
      stop = 0;
      chk("toc_done", 32'(done), 1);
      chk("toc_tmo", 32'(tmo), 0);
      tick();
`else
      // Without the timeout WAIT holds until stop
      mode = 0; run_len = 8'd1; wait_tmo = 8'd4; start = 1;
      tick();
      start = 0;
      tick();
      for (int i = 0; i < 100; i++) tick();
      chk("nt_hold", 32'(state), 2);
      chk("nt_tmo", 32'(tmo), 0);
      stop = 1;
      tick();
      stop = 0;
      wait_tmo = 8'd0;
      chk("nt_exit", 32'(state), 0);
      tick();
`endif

      // run_len 0 -> one RUN cycle
      mode = 0; run_len = 8'd0; start = 1;
      tick();
      count_busy(n);
      chk("z_busy_cycles", 32'(n), 1);
      chk("z_wait", 32'(state), 2);
      // start held in WAIT has no effect
      tick(); tick();
      chk("sw_hold", 32'(state), 2);
      stop = 1;
      tick();
      stop = 0;
      chk("sw_init", 32'(state), 0);
      tick();
      chk("sw_restart", 32'(state), 1);
      start = 0;
      tick();
      chk("sw_wait_again", 32'(state), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_fsm.md
# seq_fsm

Parametrised run/wait sequencer: the successor of the three-state INIT/RUN/WAIT controller. It adds a timed RUN phase, an auto-repeat mode with a programmable pass count, and abort on `stop` during RUN. It also adds an optional WAIT timeout and one-cycle status pulses. It sits between the operator controls (start/stop/mode) and the datapath it gates through `busy`.

## Interface
- `CNT_W`, default 8: width of the run-length and timeout counters.
- `REP_W`, default 4: width of the repeat count and pass index.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled only in INIT.
- `stop`  in  1  level; aborts RUN, ends WAIT.
- `mode`  in  1  0 = one-shot, 1 = auto-repeat; latched on start.
- `run_len`  in  CNT_W  RUN cycles per pass; latched on start; 0 treated as 1.
- `rep_cnt`  in  REP_W  extra passes in repeat mode; latched on start.
- `wait_tmo`  in  CNT_W  WAIT timeout in cycles; 0 = disabled; latched on WAIT entry.
- `state`  out  2  0 = INIT, 1 = RUN, 2 = WAIT; 3 is never driven.
- `busy`  out  1  high while state is RUN.
- `pass_idx`  out  REP_W  current pass number; 0 on the first pass.
- `done`  out  1  one-cycle pulse on WAIT→INIT caused by `stop`.
- `abort`  out  1  one-cycle pulse on RUN→INIT caused by `stop`.
- `tmo`  out  1  one-cycle pulse on WAIT→INIT caused by timeout.

## Operation
- **Reset.** While `rst_n` is low, asynchronously force `state`=INIT, `busy`=0, `pass_idx`=0, `done`=`abort`=`tmo`=0, and clear all internal counters and latches. Reset may assert in any state, mid-operation included.
- **INIT.**
  - `start`=1 → RUN.
  - On that transition: load the run counter with max(`run_len`,1), latch `mode`, load the remaining-pass counter with `rep_cnt`, set `pass_idx`=0.
  - `stop` is ignored.
- **RUN.**
  - The run counter decrements every cycle.
  - `stop`=1 → INIT with `abort` pulsed. `stop` has priority over pass completion.
  - Pass completion (run counter==1, no `stop`):
    - latched mode 0 → WAIT.
    - latched mode 1 and remaining passes >0 → stay in RUN, decrement remaining passes, increment `pass_idx`, reload the run counter from the latched length.
    - latched mode 1 and remaining passes ==0 → WAIT.
  - `start` is ignored.
- **WAIT.**
  - `stop`=1 → INIT with `done` pulsed.
  - Timeout → INIT with `tmo` pulsed (see Configuration).
  - `stop` and timeout in the same cycle: `done`=1, `tmo`=0.
  - `start` is ignored.
  - `pass_idx` holds its final value until the next start.
- **Latching.** Inputs other than `start`/`stop` are sampled only at the latch points above. Changes at any other time have no effect.

## Timing
- `start` high at edge k → `state`=RUN and `busy`=1 after edge k.
- Each pass occupies exactly max(`run_len`,1) cycles.
- Repeat mode: total RUN time = (`rep_cnt`+1)·max(`run_len`,1) cycles, with no gap between passes.
- `stop` high at edge k in RUN → `state`=INIT after edge k; `abort` is high for the single cycle following edge k.
- The `done`/`tmo` pulses follow the same rule: registered, high for the cycle after the transition edge.
- All outputs are registered; no combinational input-to-output path.
- Counter arithmetic is unsigned, CNT_W/REP_W wide, and never wraps; bounds are enforced by the terminal checks above.

## Configuration
- `SEQ_FSM_TIMEOUT_EN` defined:
  - a WAIT timeout counter is compiled in, loaded with `wait_tmo` on WAIT entry.
  - With `wait_tmo`≠0, WAIT exits to INIT after exactly `wait_tmo` WAIT cycles unless `stop` arrives first.
  - With `wait_tmo`=0, WAIT never times out.
- Undefined:
  - no timeout counter; `wait_tmo` is unused.
  - `tmo` is tied to 0.
  - WAIT exits only on `stop`.

## Test plan
- Reset mid-RUN: `run_len`=10, start, drop `rst_n` 3 cycles later → `state`=0, `busy`=0, `pass_idx`=0 immediately, without waiting for a clock edge.
- One-shot: `mode`=0, `run_len`=3, start pulse → `busy` high exactly 3 cycles, `state` 1→2. Then `stop` → `state`=0, `done` high for 1 cycle.
- Repeat: `mode`=1, `rep_cnt`=2, `run_len`=2 → RUN for 6 consecutive cycles with `pass_idx` 0,0,1,1,2,2, then WAIT with `pass_idx`=2.
- Abort: `run_len`=5, `stop` on the 2nd RUN cycle → INIT next cycle, `abort`=1 for 1 cycle, `done`=0. Repeat the test with `stop` on the final pass cycle → abort, not WAIT.
- Timeout (macro defined): `wait_tmo`=4, no `stop` → INIT after 4 WAIT cycles, `tmo`=1 for 1 cycle. Then `stop` coincident with expiry → `done`=1, `tmo`=0. Macro undefined → WAIT holds for 100 cycles.
- Edge inputs: `run_len`=0 → RUN lasts 1 cycle. `start` held high in WAIT → no effect. `start` still high on return to INIT → RUN again next edge.
